// File: rtl/core_run_controller.sv
// core_run_controller
// Control unit for a single-cycle 64-bit RISC-V datapath.
// - Decodes the fetched instruction into the datapath control bundle.
// - A run/step/halt state machine gates every architectural write, so a
//   debug host can start, single-step and stop the core.
// - Keeps saturating cycle and retired-instruction counters.

module core_run_controller #(
    parameter int BITS  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    output logic             pc_en,
    output logic [1:0]       alu_control,
    output logic             reg_write,
    output logic             mem_write,
    output logic             branch,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [BITS-1:0]  imm,
    output logic [1:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STEP  = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_DWORD   = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;

    // Immediate format selector used by the sign-extension logic.
    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_I    = 2'b01;
    localparam logic [1:0] IMM_S    = 2'b10;
    localparam logic [1:0] IMM_B    = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    // ------------------------------------------------------------------
    // Decode results (ungated)
    // ------------------------------------------------------------------
    logic       dec_legal;      // one of the supported executable instructions
    logic       dec_ecall;      // halt marker
    logic       dec_illegal;    // neither legal nor ecall
    logic       dec_reg_write;
    logic       dec_mem_write;
    logic       dec_branch;
    logic [1:0] imm_sel;

    // Combinational decode of the opcode/funct fields into the control bundle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        dec_legal     = 1'b0;
        dec_ecall     = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        alu_control   = ALU_ADD;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        imm_sel       = IMM_NONE;

        unique case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
                    dec_legal   = 1'b1;
                    alu_control = ALU_ADD;
                end else if (funct3 == F3_ADD_SUB && funct7 == F7_ALT) begin
                    dec_legal   = 1'b1;
                    alu_control = ALU_SUB;
                end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                    dec_legal   = 1'b1;
                    alu_control = ALU_AND;
                end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
                    dec_legal   = 1'b1;
                    alu_control = ALU_OR;
                end
                dec_reg_write = dec_legal;
            end

            OP_IMM: begin
                if (funct3 == F3_ADD_SUB) begin
                    dec_legal     = 1'b1;
                    dec_reg_write = 1'b1;
                    alu_control   = ALU_ADD;
                    alu_src       = 1'b1;
                    imm_sel       = IMM_I;
                end
            end

            OP_LOAD: begin
                if (funct3 == F3_DWORD) begin
                    dec_legal     = 1'b1;
                    dec_reg_write = 1'b1;
                    alu_control   = ALU_ADD;
                    alu_src       = 1'b1;
                    mem_to_reg    = 1'b1;
                    imm_sel       = IMM_I;
                end
            end

            OP_STORE: begin
                if (funct3 == F3_DWORD) begin
                    dec_legal     = 1'b1;
                    dec_mem_write = 1'b1;
                    alu_control   = ALU_ADD;
                    alu_src       = 1'b1;
                    imm_sel       = IMM_S;
                end
            end

            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    dec_legal   = 1'b1;
                    dec_branch  = 1'b1;
                    alu_control = ALU_SUB;
                    imm_sel     = IMM_B;
                end
            end

            default: begin
                // ecall is recognised only in its exact encoding; every other
                // SYSTEM-opcode word is undecodable.
                dec_ecall = (instruction == INST_ECALL);
            end
        endcase

        dec_illegal = !dec_legal && !dec_ecall;
    end

    // Sign-extend the immediate in the format chosen by the decoder.
    // The B-immediate stays in halfword units; the datapath scales it.
    always_comb begin
        imm = '0;
        unique case (imm_sel)
            IMM_I:    imm = {{(BITS-12){instruction[31]}}, instruction[31:20]};
            IMM_S:    imm = {{(BITS-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
            IMM_B:    imm = {{(BITS-12){instruction[31]}}, instruction[31], instruction[7],
                             instruction[30:25], instruction[11:8]};
            default:  imm = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Write gating
    // ------------------------------------------------------------------
    logic active;   // the core is allowed to execute this cycle
    logic execute;  // the current instruction actually retires this cycle

    // Gate all architectural writes on the run state and instruction legality.
    // Driven straight from the state register, so an asynchronous reset drops
    // these outputs without waiting for a clock edge.
    always_comb begin
        active    = (state == ST_RUN) || (state == ST_STEP);
        execute   = active && dec_legal;
        pc_en     = execute;
        reg_write = execute && dec_reg_write;
        mem_write = execute && dec_mem_write;
        branch    = execute && dec_branch;
    end

    // ------------------------------------------------------------------
    // Run/step/halt state machine
    // ------------------------------------------------------------------
    logic [1:0] state_next;
    logic       set_illegal;

    // Next-state selection; illegal beats ecall beats halt_req in RUN.
    always_comb begin
        state_next  = state;
        set_illegal = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end else if (step) begin
                    state_next = ST_STEP;
                end
            end

            ST_RUN: begin
                if (dec_illegal) begin
                    state_next  = ST_FAULT;
                    set_illegal = 1'b1;
                end else if (dec_ecall) begin
                    state_next = ST_IDLE;
                end else if (halt_req) begin
                    state_next = ST_IDLE;
                end
            end

            ST_STEP: begin
                if (dec_illegal) begin
                    state_next  = ST_FAULT;
                    set_illegal = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                // FAULT is terminal until reset.
                state_next = ST_FAULT;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sticky illegal-instruction flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal <= 1'b0;
        end else if (set_illegal) begin
            illegal <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------

    // Count cycles spent in RUN or STEP, holding at the maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (active && cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + CNT_ONE;
        end
    end

    // Count retired instructions (cycles with pc_en), holding at the maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_count <= '0;
        end else if (pc_en && retired_count != CNT_MAX) begin
            retired_count <= retired_count + CNT_ONE;
        end
    end

endmodule
